// File: rtl/seg_frame_stats_if.sv
// seg_frame_stats_if: segmented video stream in, per-frame statistics record out
interface seg_frame_stats_if #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480
);
  localparam int CW = $clog2(H_DISP * V_DISP + 1);
  localparam int XW = $clog2(H_DISP);
  localparam int YW = $clog2(V_DISP);
  logic          seg_hsync;
  logic          seg_vsync;
  logic [7:0]    seg_data;
  logic          seg_de;
  logic          stat_valid;
  logic [CW-1:0] fg_count;
  logic [XW-1:0] x_min;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_min;
  logic [YW-1:0] y_max;
  logic          bbox_empty;
  logic          geom_err;
  logic [15:0]   frame_cnt;
  modport master (
    output seg_hsync, seg_vsync, seg_data, seg_de,
    input  stat_valid, fg_count, x_min, x_max, y_min, y_max, bbox_empty, geom_err, frame_cnt
  );
  modport slave (
    input  seg_hsync, seg_vsync, seg_data, seg_de,
    output stat_valid, fg_count, x_min, x_max, y_min, y_max, bbox_empty, geom_err, frame_cnt
  );
endinterface

// File: rtl/seg_frame_stats.sv
// seg_frame_stats: per-frame foreground count, bounding box and geometry check of a segmented stream
module seg_frame_stats #(
  parameter int   H_DISP    = 640,
  parameter int   V_DISP    = 480,
  parameter int   FG_THRESH = 128,
  parameter logic VS_ACTIVE = 1'b1,
  parameter logic HS_ACTIVE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seg_frame_stats_if.slave s
);
  localparam int CW  = $clog2(H_DISP * V_DISP + 1);
  localparam int XW  = $clog2(H_DISP);
  localparam int YW  = $clog2(V_DISP);
  localparam int XCW = $clog2(H_DISP + 1);
  localparam int YCW = $clog2(V_DISP + 1);
  localparam logic [XCW-1:0] XLIM = XCW'(H_DISP);
  localparam logic [YCW-1:0] YLIM = YCW'(V_DISP);
  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;
  state_t state_q, state_d;
  logic s1_hs_q, s1_vs_q, s1_de_q, s2_vs_q, s2_de_q;
  logic [7:0] s1_data_q;
  logic [XCW-1:0] x_q, x_d;
  logic [YCW-1:0] y_q, y_d, y_base;
  logic [CW-1:0] cnt_q, cnt_d, cnt_b;
  logic [XW-1:0] xmin_q, xmin_d, xmin_b, xmax_q, xmax_d, xmax_b, px;
  logic [YW-1:0] ymin_q, ymin_d, ymin_b, ymax_q, ymax_d, ymax_b, py;
  logic err_q, err_d, err_b;
  logic boundary, line_end, fg, run, keep, viol, rep, empty;
  logic stat_valid_q, bbox_empty_q, bbox_empty_d, geom_err_q, geom_err_d;
  logic [CW-1:0] fg_count_q, fg_count_d;
  logic [XW-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [YW-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  assign boundary = s1_vs_q == VS_ACTIVE && s2_vs_q != VS_ACTIVE;
  assign line_end = !s1_de_q && s2_de_q;
  // input register stage s1 and edge-detect copy s2
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1_hs_q, s1_vs_q, s1_de_q, s1_data_q, s2_vs_q, s2_de_q} <= '0;
    else begin
      s1_hs_q   <= s.seg_hsync;
      s1_vs_q   <= s.seg_vsync;
      s1_de_q   <= s.seg_de;
      s1_data_q <= s.seg_data;
      s2_vs_q   <= s1_vs_q;
      s2_de_q   <= s1_de_q;
    end
  // frame sequencing: discard the first partial frame, then report at every boundary
  always_comb begin
    state_d = state_q;
    if (state_q == REPORT) state_d = ACTIVE;
    else if (boundary) state_d = (state_q == IDLE) ? ACTIVE : REPORT;
  end
  // accumulator update; REPORT/IDLE restart from init values so the REPORT-cycle pixel still lands in the new frame
  always_comb begin
    run    = state_q != IDLE;
    keep   = state_q == ACTIVE;
    fg     = s1_de_q && s1_data_q >= 8'(FG_THRESH);
    y_base = keep ? y_q : '0;
    px     = x_q[XW-1:0];
    py     = y_base[YW-1:0];
    x_d    = line_end ? '0 : (s1_de_q && x_q != XLIM) ? x_q + 1'b1 : x_q;
    y_d    = (run && line_end && y_base != YLIM) ? y_base + 1'b1 : y_base;
    cnt_b  = keep ? cnt_q : '0;
    xmin_b = keep ? xmin_q : '1;
    xmax_b = keep ? xmax_q : '0;
    ymin_b = keep ? ymin_q : '1;
    ymax_b = keep ? ymax_q : '0;
    err_b  = keep && err_q;
    viol   = (line_end && (x_q != XLIM || y_base == YLIM)) ||
             (s1_de_q && (x_q == XLIM || s1_hs_q == HS_ACTIVE || s1_vs_q == VS_ACTIVE)) ||
             (boundary && y_d != YLIM);
    cnt_d  = cnt_b + CW'(run && fg);
    xmin_d = (run && fg && px < xmin_b) ? px : xmin_b;
    xmax_d = (run && fg && px > xmax_b) ? px : xmax_b;
    ymin_d = (run && fg && py < ymin_b) ? py : ymin_b;
    ymax_d = (run && fg && py > ymax_b) ? py : ymax_b;
    err_d  = err_b || (run && viol);
  end
  // state, counters and accumulators
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      err_q   <= err_d;
    end
  // record contents; an empty frame reports a zero bounding box
  always_comb begin
    rep          = state_q == REPORT;
    empty        = cnt_q == '0;
    fg_count_d   = cnt_q;
    x_min_d      = empty ? '0 : xmin_q;
    x_max_d      = empty ? '0 : xmax_q;
    y_min_d      = empty ? '0 : ymin_q;
    y_max_d      = empty ? '0 : ymax_q;
    bbox_empty_d = empty;
    geom_err_d   = err_q;
    frame_cnt_d  = frame_cnt_q + 16'd1;
  end
  // record registers, loaded only in REPORT and held otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_valid_q <= 1'b0;
      fg_count_q   <= '0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      bbox_empty_q <= 1'b0;
      geom_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      stat_valid_q <= rep;
      if (rep) begin
        fg_count_q   <= fg_count_d;
        x_min_q      <= x_min_d;
        x_max_q      <= x_max_d;
        y_min_q      <= y_min_d;
        y_max_q      <= y_max_d;
        bbox_empty_q <= bbox_empty_d;
        geom_err_q   <= geom_err_d;
        frame_cnt_q  <= frame_cnt_d;
      end
    end
  assign s.stat_valid = stat_valid_q;
  assign s.fg_count   = fg_count_q;
  assign s.x_min      = x_min_q;
  assign s.x_max      = x_max_q;
  assign s.y_min      = y_min_q;
  assign s.y_max      = y_max_q;
  assign s.bbox_empty = bbox_empty_q;
  assign s.geom_err   = geom_err_q;
  assign s.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_seg_frame_stats.sv
// tb_seg_frame_stats: frame-level model of seg_frame_stats checked every cycle, plus literal spot checks
module tb_seg_frame_stats;
  localparam int H = 16;
  localparam int V = 12;
  localparam int FG = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg_frame_stats_if #(.H_DISP(H), .V_DISP(V)) bus ();
  seg_frame_stats #(.H_DISP(H), .V_DISP(V), .FG_THRESH(FG), .VS_ACTIVE(1'b1), .HS_ACTIVE(1'b1))
    dut (.clk(clk), .rst(rst), .s(bus));
  typedef struct {int cnt; int xmn; int xmx; int ymn; int ymx; int empty; int err; int fc;} rec_t;
  typedef struct {int due; rec_t r;} exp_t;
  typedef struct {int nl; int sl; int x0; int x1; int y0; int y1; int val;} desc_t;
  exp_t  q[$];
  rec_t  cur;
  desc_t d_cur;
  bit    active = 1'b0;
  int    frames = 0;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  desc_t blank, rect, p128, p127, shrt, l13;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  // expected record computed directly from the frame's pixel description
  function automatic rec_t model(desc_t d);
    rec_t r;
    r = '{cnt: 0, xmn: H, xmx: -1, ymn: V, ymx: -1, empty: 0, err: 0, fc: 0};
    for (int y = 0; y < d.nl; y++)
      for (int x = 0; x < ((y == d.sl) ? H - 1 : H); x++)
        if (x >= d.x0 && x <= d.x1 && y >= d.y0 && y <= d.y1 && d.val >= FG) begin
          r.cnt++;
          if (x < r.xmn) r.xmn = x;
          if (x > r.xmx) r.xmx = x;
          if (y < r.ymn) r.ymn = y;
          if (y > r.ymx) r.ymx = y;
        end
    r.empty = (r.cnt == 0) ? 1 : 0;
    if (r.empty != 0) begin
      r.xmn = 0; r.xmx = 0; r.ymn = 0; r.ymx = 0;
    end
    r.err = (d.nl != V || (d.sl >= 0 && d.sl < d.nl)) ? 1 : 0;
    return r;
  endfunction
  // every cycle out of reset: stat_valid timing and held record against the model
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bit ev;
      ev = q.size() > 0 && q[0].due == cyc;
      if (ev) begin
        cur = q[0].r;
        void'(q.pop_front());
      end
      check("stat_valid", bus.stat_valid, ev);
      check("fg_count", bus.fg_count, cur.cnt);
      check("x_min", bus.x_min, cur.xmn);
      check("x_max", bus.x_max, cur.xmx);
      check("y_min", bus.y_min, cur.ymn);
      check("y_max", bus.y_max, cur.ymx);
      check("bbox_empty", bus.bbox_empty, cur.empty);
      check("geom_err", bus.geom_err, cur.err);
      check("frame_cnt", bus.frame_cnt, cur.fc);
    end
  end
  task automatic drv(bit hs, bit vs, bit de, int data);
    @(negedge clk);
    bus.seg_hsync = hs;
    bus.seg_vsync = vs;
    bus.seg_de    = de;
    bus.seg_data  = 8'(data);
  endtask
  task automatic vs_pulse(desc_t d);
    drv(0, 1, 0, 0);
    if (active) begin
      exp_t e;
      frames = (frames + 1) & 32'hFFFF;
      e.r = model(d_cur);
      e.r.fc = frames;
      e.due = cyc + 3;
      q.push_back(e);
    end
    active = 1'b1;
    d_cur = d;
    drv(0, 1, 0, 0);
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
  endtask
  task automatic body(desc_t d, int ya, int yb);
    for (int y = ya; y < yb; y++) begin
      drv(1, 0, 0, 0);
      drv(1, 0, 0, 0);
      drv(0, 0, 0, 0);
      for (int x = 0; x < ((y == d.sl) ? H - 1 : H); x++)
        drv(0, 0, 1, (x >= d.x0 && x <= d.x1 && y >= d.y0 && y <= d.y1) ? d.val : 0);
      drv(0, 0, 0, 0);
    end
  endtask
  task automatic lit(string n, int cnt, int xmn, int xmx, int ymn, int ymx, int empty, int err, int fc);
    repeat (2) @(negedge clk);
    check({n, " fg_count"}, bus.fg_count, cnt);
    check({n, " x_min"}, bus.x_min, xmn);
    check({n, " x_max"}, bus.x_max, xmx);
    check({n, " y_min"}, bus.y_min, ymn);
    check({n, " y_max"}, bus.y_max, ymx);
    check({n, " bbox_empty"}, bus.bbox_empty, empty);
    check({n, " geom_err"}, bus.geom_err, err);
    check({n, " frame_cnt"}, bus.frame_cnt, fc);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    cur = '{default: 0};
    active = 1'b0;
    frames = 0;
    #1;
    check("rst stat_valid", bus.stat_valid, 0);
    check("rst fg_count", bus.fg_count, 0);
    check("rst x_max", bus.x_max, 0);
    check("rst y_max", bus.y_max, 0);
    check("rst geom_err", bus.geom_err, 0);
    check("rst frame_cnt", bus.frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    blank = '{nl: V, sl: -1, x0: 0, x1: -1, y0: 0, y1: -1, val: 0};
    rect  = '{nl: V, sl: -1, x0: 4, x1: 9, y0: 3, y1: 7, val: 255};
    p128  = '{nl: V, sl: -1, x0: H - 1, x1: H - 1, y0: V - 1, y1: V - 1, val: 128};
    p127  = '{nl: V, sl: -1, x0: H - 1, x1: H - 1, y0: V - 1, y1: V - 1, val: 127};
    shrt  = '{nl: V, sl: 10, x0: 0, x1: -1, y0: 0, y1: -1, val: 0};
    l13   = '{nl: V + 1, sl: -1, x0: 0, x1: -1, y0: 0, y1: -1, val: 0};
    cur = '{default: 0};
    bus.seg_hsync = 1'b0;
    bus.seg_vsync = 1'b0;
    bus.seg_de    = 1'b0;
    bus.seg_data  = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vs_pulse(blank);
    body(blank, 0, V);
    vs_pulse(blank);
    lit("first report", 0, 0, 0, 0, 0, 1, 0, 1);
    body(blank, 0, V);
    vs_pulse(rect);
    body(rect, 0, V);
    vs_pulse(p128);
    lit("rectangle", 30, 4, 9, 3, 7, 0, 0, 3);
    body(p128, 0, V);
    vs_pulse(p127);
    lit("corner 128", 1, 15, 15, 11, 11, 0, 0, 4);
    body(p127, 0, V);
    vs_pulse(shrt);
    lit("corner 127", 0, 0, 0, 0, 0, 1, 0, 5);
    body(shrt, 0, V);
    vs_pulse(l13);
    lit("short line", 0, 0, 0, 0, 0, 1, 1, 6);
    body(l13, 0, V + 1);
    vs_pulse(rect);
    lit("extra line", 0, 0, 0, 0, 0, 1, 1, 7);
    body(rect, 0, V);
    vs_pulse(blank);
    lit("clean again", 30, 4, 9, 3, 7, 0, 0, 8);
    body(blank, 0, 6);
    do_reset();
    body(blank, 6, V);
    vs_pulse(blank);
    body(blank, 0, V);
    vs_pulse(blank);
    lit("after reset", 0, 0, 0, 0, 0, 1, 0, 1);
    body(blank, 0, V);
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    frames = 32'hFFFF;
    cur.fc = 32'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("forced frame_cnt", bus.frame_cnt, 32'hFFFF);
    vs_pulse(blank);
    lit("wrap", 0, 0, 0, 0, 0, 1, 0, 0);
    body(blank, 0, 2);
    check("queue drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
